// File: rtl/memory_module_virtual_memory.sv
// Demand-paged byte memory: a fully associative page table maps VPNs onto physical frames when a page is first written.
// Optional statistics outputs are enabled with the macro VMEM_STATS_EN.
module memory_module_virtual_memory #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          PAGE_BITS  = 4,
    parameter int          NUM_FRAMES = 16,
    parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  rd_mapped,
    output logic                  wr_err,
    output logic                  full
`ifdef VMEM_STATS_EN
    ,
    output logic [15:0]                    rd_count,
    output logic [15:0]                    wr_count,
    output logic [$clog2(NUM_FRAMES):0]    frames_used
`endif
);

    localparam int VPN_W     = ADDR_WIDTH - PAGE_BITS;
    localparam int PAGE_SIZE = 1 << PAGE_BITS;
    localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int MEM_DEPTH = NUM_FRAMES * PAGE_SIZE;
    localparam int IDX_W     = FRAME_W + PAGE_BITS;

    logic [NUM_FRAMES-1:0] r_valid;
    logic [VPN_W-1:0]      r_tag [NUM_FRAMES];
    logic [7:0]            r_mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  r_written;

    logic       r_rd_valid;
    logic       r_rd_mapped;
    logic [7:0] r_rd_data;
    logic       r_wr_err;

    logic [VPN_W-1:0]   w_wr_vpn;
    logic [VPN_W-1:0]   w_rd_vpn;
    logic               w_wr_hit;
    logic [FRAME_W-1:0] w_wr_frame;
    logic               w_rd_hit;
    logic [FRAME_W-1:0] w_rd_frame;
    logic               w_free_found;
    logic [FRAME_W-1:0] w_free_frame;
    logic [FRAME_W-1:0] w_wr_tgt;
    logic               w_wr_alloc;
    logic               w_wr_commit;
    logic               w_wr_drop;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_wr_vpn = wr_addr[ADDR_WIDTH-1:PAGE_BITS];
    assign w_rd_vpn = rd_addr[ADDR_WIDTH-1:PAGE_BITS];

    always_comb begin
        w_wr_hit     = 1'b0;
        w_wr_frame   = '0;
        w_rd_hit     = 1'b0;
        w_rd_frame   = '0;
        w_free_found = 1'b0;
        w_free_frame = '0;
        for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
            if (r_valid[i] && (r_tag[i] == w_wr_vpn)) begin
                w_wr_hit   = 1'b1;
                w_wr_frame = FRAME_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == w_rd_vpn)) begin
                w_rd_hit   = 1'b1;
                w_rd_frame = FRAME_W'(i);
            end
            // Guarded so the lowest-index free frame wins
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_frame = FRAME_W'(i);
            end
        end
    end

    assign w_wr_alloc  = wr_en && !w_wr_hit && w_free_found;
    assign w_wr_commit = wr_en && (w_wr_hit || w_free_found);
    assign w_wr_drop   = wr_en && !w_wr_hit && !w_free_found;
    assign w_wr_tgt    = w_wr_hit ? w_wr_frame : w_free_frame;
    assign w_wr_idx    = {w_wr_tgt, wr_addr[PAGE_BITS-1:0]};
    assign w_rd_idx    = {w_rd_frame, rd_addr[PAGE_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (!reset && w_wr_commit) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            r_written <= '0;
        end else begin
            if (w_wr_alloc) begin
                r_valid[w_free_frame] <= 1'b1;
                r_tag[w_free_frame]   <= w_wr_vpn;
                for (int unsigned b = 0; b < PAGE_SIZE; b++) begin
                    r_written[{w_free_frame, PAGE_BITS'(b)}] <= 1'b0;
                end
            end
            // Later assignment overrides the frame-wide clear above
            if (w_wr_commit) begin
                r_written[w_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_mapped <= 1'b0;
            r_rd_data   <= FILL_BYTE;
            r_wr_err    <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_wr_err   <= w_wr_drop;
            if (rd_en) begin
                r_rd_mapped <= w_rd_hit;
                r_rd_data   <= (w_rd_hit && r_written[w_rd_idx]) ? r_mem[w_rd_idx] : FILL_BYTE;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_mapped = r_rd_mapped;
    assign rd_data   = r_rd_data;
    assign wr_err    = r_wr_err;
    assign full      = &r_valid;

`ifdef VMEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (rd_en && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_wr_commit && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    always_comb begin
        frames_used = '0;
        for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
            frames_used = frames_used + $bits(frames_used)'(r_valid[i]);
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_memory_module_virtual_memory.sv
// Directed and randomized bench for memory_module_virtual_memory against a page-list / sparse-byte-map reference model.
module tb_memory_module_virtual_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_mapped;
    logic        wr_err;
    logic        full;
`ifdef VMEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [4:0]  frames_used;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: list of mapped pages in allocation order and a sparse byte map
    logic [27:0] m_pages[$];
    logic [7:0]  m_mem[logic [31:0]];
    int          m_rd = 0;
    int          m_wr = 0;
    logic [31:0] known_addr;
    logic [7:0]  known_data;

    memory_module_virtual_memory #(
        .ADDR_WIDTH (32),
        .PAGE_BITS  (4),
        .NUM_FRAMES (16),
        .FILL_BYTE  (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_mapped (rd_mapped),
        .wr_err    (wr_err),
        .full      (full)
`ifdef VMEM_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .frames_used (frames_used)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_mapped(input logic [27:0] vpn);
        foreach (m_pages[i]) begin
            if (m_pages[i] == vpn) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [31:0] wa, input logic [7:0] wd,
                        input logic re, input logic [31:0] ra, input string tag);
        logic       e_valid;
        logic       e_mapped;
        logic [7:0] e_data;
        logic       e_err;
        e_valid  = 1'b0;
        e_mapped = 1'b0;
        e_data   = 8'h00;
        e_err    = 1'b0;
        if (rst) begin
            m_pages.delete();
            m_mem.delete();
            m_rd = 0;
            m_wr = 0;
        end else begin
            if (re) begin
                e_valid  = 1'b1;
                e_mapped = is_mapped(ra[31:4]);
                e_data   = (e_mapped && m_mem.exists(ra)) ? m_mem[ra] : 8'h00;
                m_rd++;
            end
            if (we) begin
                if (is_mapped(wa[31:4])) begin
                    m_mem[wa] = wd;
                    m_wr++;
                end else if (m_pages.size() < 16) begin
                    m_pages.push_back(wa[31:4]);
                    m_mem[wa] = wd;
                    m_wr++;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_valid));
        check({tag, ".wr_err"}, 32'(wr_err), 32'(e_err));
        check({tag, ".full"}, 32'(full), 32'(m_pages.size() == 16));
        if (rst || re) begin
            check({tag, ".rd_mapped"}, 32'(rd_mapped), 32'(e_mapped));
            check({tag, ".rd_data"}, 32'(rd_data), 32'(e_data));
        end
`ifdef VMEM_STATS_EN
        check({tag, ".rd_count"}, 32'(rd_count), 32'(m_rd));
        check({tag, ".wr_count"}, 32'(wr_count), 32'(m_wr));
        check({tag, ".frames_used"}, 32'(frames_used), 32'(m_pages.size()));
`endif
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [27:0] pool [24];
        logic        we;
        logic        re;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [7:0]  wd;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        known_addr = 32'h0000_0010;
        known_data = 8'hA5;

        // Requests during reset are ignored
        step(1'b1, 1'b1, 32'h0000_0040, 8'h55, 1'b1, 32'h0000_0040, "rst0");
        step(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0040, "rst1");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0040, "post_rst_rd");

        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h1234_5678, "unmapped_rd");
        step(1'b0, 1'b1, 32'h0000_0010, 8'hA5, 1'b0, 32'h0, "wr_a5");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0010, "rd_a5");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0011, "rd_unwritten");
        step(1'b0, 1'b1, 32'h0000_0200, 8'h3C, 1'b1, 32'h0000_0200, "rbw_alloc");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0200, "rd_3c");
        step(1'b0, 1'b1, 32'h0000_0201, 8'h99, 1'b1, 32'h0000_0201, "rbw_mapped");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_0201, "rd_99");
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 8'h77, 1'b0, 32'h0, "wr_top");
        step(1'b0, 1'b1, 32'h0000_000F, 8'h11, 1'b0, 32'h0, "wr_low");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'hFFFF_FFFF, "rd_top");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_000F, "rd_low");

        // Random traffic over a VPN pool larger than the frame count, so drops occur
        foreach (pool[i]) pool[i] = 28'($urandom);
        for (int unsigned n = 0; n < 300; n++) begin
            we = ($urandom_range(0, 9) < 6);
            re = ($urandom_range(0, 9) < 6);
            wa = {pool[$urandom_range(0, 23)], 4'($urandom_range(0, 15))};
            wd = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : {pool[$urandom_range(0, 23)], 4'($urandom_range(0, 15))};
            step(1'b0, we, wa, wd, re, ra, "rand");
        end

        // Reset mid-stream with a read in flight
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, known_addr, "pre_rst_rd");
        step(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, "mid_rst");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, known_addr, "rd_after_rst");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'hFFFF_FFFF, "rd_top_after_rst");

        // Fill all frames, then overflow
        for (int unsigned p = 0; p < 16; p++) begin
            step(1'b0, 1'b1, 32'(p * 16), 8'(p + 1), 1'b0, 32'h0, "fill");
        end
        step(1'b0, 1'b1, 32'h0000_1000, 8'hEE, 1'b0, 32'h0, "overflow");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_1000, "rd_dropped");
        step(1'b0, 1'b1, 32'h0000_00F3, 8'h5A, 1'b1, 32'h0000_00F0, "wr_full_mapped");
        step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_00F3, "rd_full_mapped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
